id_exe_stage: RTL

ID_EXE_STAGE -- requirements
Module: id_exe_stage

---
 rtl/id_exe_stage_pkg.sv | 49 ++++
 rtl/id_exe_stage_cond_check.sv | 37 +++
 rtl/id_exe_stage.sv | 101 ++++++++++
 3 files changed

// File: rtl/id_exe_stage_pkg.sv
// id_exe_stage_pkg: shared processor constants (condition codes, ALU commands) and pipeline helpers.
package id_exe_stage_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       mem_read;
        logic       mem_write;
        logic       wb_en;
        logic       s;
        logic       b;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = ctrl_t'({EXE_NOP, 5'b00000});

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/id_exe_stage_cond_check.sv
// cond_check: combinational ARM condition-field evaluation against the {N,Z,C,V} status flags.
// Ports: cond (instruction bits [31:28]), sr_flags ({N,Z,C,V}) -> pass (condition holds).
module cond_check
    import id_exe_stage_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] sr_flags,
    output logic       pass
);

    logic n, z, c, v;

    assign {n, z, c, v} = sr_flags;

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_exe_stage.sv
// id_exe_stage: ID/EX pipeline register with condition gating, flush/freeze handling and bubble counting.
// Ports: clk, rst (async active-low); freeze/flush/hazard pipeline control; cond/sr_flags condition inputs;
//        *_in decode fields -> registered counterparts, plus valid and a saturating bubble_count.
module id_exe_stage
    import id_exe_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              hazard,
    input  logic [3:0]        cond,
    input  logic [3:0]        sr_flags,
    input  logic [3:0]        exe_cmd_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              wb_en_in,
    input  logic              s_in,
    input  logic              b_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_24_in,
    input  logic [3:0]        dest_in,
    input  logic [3:0]        src1_in,
    input  logic [3:0]        src2_in,
    output logic [3:0]        exe_cmd,
    output logic              mem_read,
    output logic              mem_write,
    output logic              wb_en,
    output logic              s,
    output logic              b,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] val_rn,
    output logic [DATA_W-1:0] val_rm,
    output logic              imm,
    output logic [11:0]       shift_operand,
    output logic [23:0]       signed_imm_24,
    output logic [3:0]        dest,
    output logic [3:0]        src1,
    output logic [3:0]        src2,
    output logic              valid,
    output logic [15:0]       bubble_count
);

    logic  cond_ok;
    logic  pass;
    ctrl_t ctrl_q;
    ctrl_t ctrl_in;

    cond_check u_cond_check (
        .cond     (cond),
        .sr_flags (sr_flags),
        .pass     (cond_ok)
    );

    // A hazard turns the incoming instruction into a bubble exactly like a failed condition.
    assign pass    = cond_ok && !hazard;
    assign ctrl_in = ctrl_t'({exe_cmd_in, mem_read_in, mem_write_in, wb_en_in, s_in, b_in});
    assign {exe_cmd, mem_read, mem_write, wb_en, s, b} = ctrl_q;

    // Flush only kills control and validity; the data fields keep whatever was last captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q        <= '0;
            valid         <= 1'b0;
            bubble_count  <= '0;
            pc            <= '0;
            val_rn        <= '0;
            val_rm        <= '0;
            imm           <= 1'b0;
            shift_operand <= '0;
            signed_imm_24 <= '0;
            dest          <= '0;
            src1          <= '0;
            src2          <= '0;
        end else if (flush) begin
            ctrl_q       <= CTRL_BUBBLE;
            valid        <= 1'b0;
            bubble_count <= sat_inc(bubble_count);
        end else if (!freeze) begin
            ctrl_q        <= pass ? ctrl_in : CTRL_BUBBLE;
            valid         <= pass;
            bubble_count  <= pass ? bubble_count : sat_inc(bubble_count);
            pc            <= pc_in;
            val_rn        <= val_rn_in;
            val_rm        <= val_rm_in;
            imm           <= imm_in;
            shift_operand <= shift_operand_in;
            signed_imm_24 <= signed_imm_24_in;
            dest          <= dest_in;
            src1          <= src1_in;
            src2          <= src2_in;
        end
    end

endmodule
